// File: rtl/cam_source.sv
`default_nettype none
// ============================================================================
// Module   : cam_source
// Purpose  : Camera byte-interface transmitter. Emulates a parallel camera
//            sensor by driving pclk/vsync/href/pixel with RGB565 test
//            patterns, high byte first, for the downstream capture path.
// Ports    : clk_pixel_in    - system clock
//            rst_n_in        - asynchronous active-low reset
//            run_in          - level, high enables frame generation
//            pattern_sel_in  - test pattern, latched at each VSYNC entry
//            pclk_out        - emulated pixel clock (CLK_DIV cycles per half)
//            vsync_out       - frame sync, active-high
//            href_out        - line valid, active-high
//            pixel_out       - RGB565 byte stream, 0 outside href
//            busy_out        - high in every state except IDLE
//            frame_count_out - completed-frame counter (CAM_SOURCE_FRAME_CNT_EN)
// Options  : define CAM_SOURCE_FRAME_CNT_EN to add frame_count_out.
// Revision : 1.0 - initial release
// ============================================================================
module cam_source #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int CLK_DIV   = 4,
    parameter int HBLANK    = 16,
    parameter int VSYNC_LEN = 8,
    parameter int VBACK     = 8
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic       run_in,
    input  logic [1:0] pattern_sel_in,
    output logic       pclk_out,
    output logic       vsync_out,
    output logic       href_out,
    output logic [7:0] pixel_out,
    output logic       busy_out
`ifdef CAM_SOURCE_FRAME_CNT_EN
    ,
    output logic [7:0] frame_count_out
`endif
);

    localparam int c_XW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_DW      = $clog2(CLK_DIV);
    localparam int c_BLK_MAX = (VSYNC_LEN > VBACK) ?
                               ((VSYNC_LEN > HBLANK) ? VSYNC_LEN : HBLANK) :
                               ((VBACK > HBLANK) ? VBACK : HBLANK);
    localparam int c_PW      = (c_BLK_MAX > 1) ? $clog2(c_BLK_MAX) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST   = c_YW'(HEIGHT - 1);
    localparam logic [c_PW-1:0] c_VS_LAST  = c_PW'(VSYNC_LEN - 1);
    localparam logic [c_PW-1:0] c_VB_LAST  = c_PW'(VBACK - 1);
    localparam logic [c_PW-1:0] c_HB_LAST  = c_PW'(HBLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_LINE   = 3'd3,
        S_HBLANK = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_DW-1:0] r_div;
    logic            r_pclk;
    logic            r_vsync;
    logic            r_href;
    logic [7:0]      r_pixel;
    logic [7:0]      r_lo;       // low byte of the pixel whose high byte is on the bus
    logic            r_byte;     // 1: low byte goes out on the next fall
    logic            r_busy;
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic [c_PW-1:0] r_period;
    logic [1:0]      r_pattern;
`ifdef CAM_SOURCE_FRAME_CNT_EN
    logic [7:0]      r_frame_cnt;
`endif

    // Shift/mask arithmetic keeps every bit of the arguments in use.
    function automatic logic [15:0] pattern_rgb(input logic [1:0]  pat,
                                                input logic [31:0] x,
                                                input logic [31:0] y);
        logic [4:0] lvl;
        logic       tile;
        logic       bar;
        lvl  = 5'((x >> 4) & 32'h1F);
        tile = 1'(((x ^ y) >> 4) & 32'h1);
        bar  = 1'((x >> 5) & 32'h1);
        case (pat)
            2'd0:    pattern_rgb = 16'hFFFF;
            2'd1:    pattern_rgb = tile ? 16'h0000 : 16'hFFFF;
            2'd2:    pattern_rgb = bar ? 16'h0000 : 16'hFFFF;
            default: pattern_rgb = {lvl, lvl, lvl[4], lvl};
        endcase
    endfunction

    // Pixel about to be loaded: the next column inside a line, or column 0
    // of the next row (HBLANK) / of row 0 (VBACK, where r_y is already 0).
    logic [31:0] w_x_arg;
    logic [31:0] w_y_arg;
    logic [15:0] w_rgb;
    logic        w_fall;

    assign w_x_arg = (r_state == S_LINE) ? 32'(r_x) + 32'd1 : 32'd0;
    assign w_y_arg = (r_state == S_HBLANK) ? 32'(r_y) + 32'd1 : 32'(r_y);
    assign w_rgb   = pattern_rgb(r_pattern, w_x_arg, w_y_arg);

    // The only cycle on which state and outputs may move: pclk going low.
    assign w_fall  = (r_state != S_IDLE) && r_pclk && (r_div == c_DIV_LAST);

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_pclk      <= 1'b0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_pixel     <= 8'h00;
            r_lo        <= 8'h00;
            r_byte      <= 1'b0;
            r_busy      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_period    <= '0;
            r_pattern   <= 2'd0;
`ifdef CAM_SOURCE_FRAME_CNT_EN
            r_frame_cnt <= 8'd0;
`endif
        end else if (r_state == S_IDLE) begin
            r_div  <= '0;
            r_pclk <= 1'b0;
            if (run_in) begin
                r_state   <= S_VSYNC;
                r_vsync   <= 1'b1;
                r_busy    <= 1'b1;
                r_period  <= '0;
                r_pattern <= pattern_sel_in;
            end
        end else begin
            if (r_div == c_DIV_LAST) begin
                r_div  <= '0;
                r_pclk <= ~r_pclk;
            end else begin
                r_div  <= r_div + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    S_VSYNC: begin
                        if (r_period == c_VS_LAST) begin
                            r_period <= '0;
                            r_vsync  <= 1'b0;
                            r_state  <= S_VBACK;
                        end else begin
                            r_period <= r_period + 1'b1;
                        end
                    end
                    S_VBACK: begin
                        if (r_period == c_VB_LAST) begin
                            r_period <= '0;
                            r_state  <= S_LINE;
                            r_href   <= 1'b1;
                            r_pixel  <= w_rgb[15:8];
                            r_lo     <= w_rgb[7:0];
                            r_byte   <= 1'b1;
                        end else begin
                            r_period <= r_period + 1'b1;
                        end
                    end
                    S_LINE: begin
                        if (r_byte) begin
                            r_pixel <= r_lo;
                            r_byte  <= 1'b0;
                        end else if (r_x == c_X_LAST) begin
                            r_x     <= '0;
                            r_href  <= 1'b0;
                            r_pixel <= 8'h00;
                            r_state <= S_HBLANK;
                        end else begin
                            r_x     <= r_x + 1'b1;
                            r_pixel <= w_rgb[15:8];
                            r_lo    <= w_rgb[7:0];
                            r_byte  <= 1'b1;
                        end
                    end
                    S_HBLANK: begin
                        if (r_period == c_HB_LAST) begin
                            r_period <= '0;
                            if (r_y == c_Y_LAST) begin
                                r_y <= '0;
`ifdef CAM_SOURCE_FRAME_CNT_EN
                                r_frame_cnt <= r_frame_cnt + 1'b1;
`endif
                                if (run_in) begin
                                    r_state   <= S_VSYNC;
                                    r_vsync   <= 1'b1;
                                    r_pattern <= pattern_sel_in;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_y     <= r_y + 1'b1;
                                r_state <= S_LINE;
                                r_href  <= 1'b1;
                                r_pixel <= w_rgb[15:8];
                                r_lo    <= w_rgb[7:0];
                                r_byte  <= 1'b1;
                            end
                        end else begin
                            r_period <= r_period + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign pclk_out  = r_pclk;
    assign vsync_out = r_vsync;
    assign href_out  = r_href;
    assign pixel_out = r_pixel;
    assign busy_out  = r_busy;
`ifdef CAM_SOURCE_FRAME_CNT_EN
    assign frame_count_out = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_source
// Purpose  : Self-checking bench for cam_source. Two instances: a tiny frame
//            geometry (A) and a wide one (B) that reaches x=256. Expected bytes
//            are queued when a frame is requested and popped on every pclk
//            rising edge with href high.
// Options  : CAM_SOURCE_FRAME_CNT_EN enables frame_count_out checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_source;

    localparam int A_W = 4,   A_H = 2, A_CD = 2, A_HB = 2, A_VS = 3, A_VB = 2;
    localparam int B_W = 272, B_H = 2, B_CD = 2, B_HB = 2, B_VS = 2, B_VB = 2;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b, run_a, run_b;
    logic [1:0] pat_a, pat_b;
    logic       pclk_a, vsync_a, href_a, busy_a;
    logic       pclk_b, vsync_b, href_b, busy_b;
    logic [7:0] pixel_a, pixel_b;
`ifdef CAM_SOURCE_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    always #5 clk = ~clk;

    cam_source #(.WIDTH(A_W), .HEIGHT(A_H), .CLK_DIV(A_CD), .HBLANK(A_HB),
                 .VSYNC_LEN(A_VS), .VBACK(A_VB)) u_dut_a (
        .clk_pixel_in(clk), .rst_n_in(rst_n_a), .run_in(run_a),
        .pattern_sel_in(pat_a), .pclk_out(pclk_a), .vsync_out(vsync_a),
        .href_out(href_a), .pixel_out(pixel_a), .busy_out(busy_a)
`ifdef CAM_SOURCE_FRAME_CNT_EN
        , .frame_count_out(fc_a)
`endif
    );

    cam_source #(.WIDTH(B_W), .HEIGHT(B_H), .CLK_DIV(B_CD), .HBLANK(B_HB),
                 .VSYNC_LEN(B_VS), .VBACK(B_VB)) u_dut_b (
        .clk_pixel_in(clk), .rst_n_in(rst_n_b), .run_in(run_b),
        .pattern_sel_in(pat_b), .pclk_out(pclk_b), .vsync_out(vsync_b),
        .href_out(href_b), .pixel_out(pixel_b), .busy_out(busy_b)
`ifdef CAM_SOURCE_FRAME_CNT_EN
        , .frame_count_out(fc_b)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int prev_pclk[2], prev_vs[2], prev_href[2];
    int vs_cnt[2], href_cnt[2], line_in_frame[2], lines_total[2];
    int vs_pulses[2], exp_fc[2];

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference pattern model in RGB565.
    function automatic logic [15:0] exp_rgb(input int pat, input int x, input int y);
        int r, g;
        case (pat)
            0: return 16'hFFFF;
            1: return ((((x / 16) % 2) ^ ((y / 16) % 2)) == 0) ? 16'hFFFF : 16'h0000;
            2: return (((x / 32) % 2) == 0) ? 16'hFFFF : 16'h0000;
            default: begin
                r = (x / 16) % 32;
                g = r * 2 + (x / 256) % 2;
                return 16'((r << 11) | (g << 5) | r);
            end
        endcase
    endfunction

    task automatic push_frame(input int id, input int pat);
        logic [15:0] rgb;
        int w, h;
        w = (id == 0) ? A_W : B_W;
        h = (id == 0) ? A_H : B_H;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                rgb = exp_rgb(pat, x, y);
                if (id == 0) begin sb_a.push_back(rgb[15:8]); sb_a.push_back(rgb[7:0]); end
                else         begin sb_b.push_back(rgb[15:8]); sb_b.push_back(rgb[7:0]); end
            end
        end
    endtask

    task automatic mon_reset(input int id);
        prev_pclk[id] = 0; prev_vs[id] = 0; prev_href[id] = 0;
        vs_cnt[id] = 0; href_cnt[id] = 0; line_in_frame[id] = 0; exp_fc[id] = 0;
        if (id == 0) sb_a.delete(); else sb_b.delete();
    endtask

    task automatic mon_step(input int id, input logic pclk, input logic vs,
                            input logic hr, input logic [7:0] pix);
        logic [7:0] exp_b;
        int n;
        if (pclk && prev_pclk[id] == 0) begin
            if (hr) begin
                href_cnt[id]++;
                n = (id == 0) ? sb_a.size() : sb_b.size();
                if (n == 0) check_val("byte_expected", n, 1);
                else begin
                    exp_b = (id == 0) ? sb_a.pop_front() : sb_b.pop_front();
                    check_val(id == 0 ? "a_pixel" : "b_pixel", pix, exp_b);
                end
            end else begin
                check_val("blank_pixel", pix, 0);
            end
            if (vs) vs_cnt[id]++;
        end
        if (vs && prev_vs[id] == 0) vs_pulses[id]++;
        if (!vs && prev_vs[id] != 0) begin
            check_val("vsync_len", vs_cnt[id], (id == 0) ? A_VS : B_VS);
            vs_cnt[id] = 0;
        end
        if (!hr && prev_href[id] != 0) begin
            check_val("line_len", href_cnt[id], 2 * ((id == 0) ? A_W : B_W));
            href_cnt[id] = 0;
            lines_total[id]++;
            line_in_frame[id]++;
            if (line_in_frame[id] == ((id == 0) ? A_H : B_H)) begin
                line_in_frame[id] = 0;
                exp_fc[id]++;
            end
        end
        prev_pclk[id] = int'(pclk);
        prev_vs[id]   = int'(vs);
        prev_href[id] = int'(hr);
    endtask

    always @(negedge clk) begin
        mon_step(0, pclk_a, vsync_a, href_a, pixel_a);
        mon_step(1, pclk_b, vsync_b, href_b, pixel_b);
    end

    task automatic wait_busy(input int id, input logic lvl, input int budget);
        int n = 0;
        while (((id == 0) ? busy_a : busy_b) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_wait", (id == 0) ? busy_a : busy_b, lvl);
    endtask

    task automatic wait_vsync(input int id, input int target, input int budget);
        int n = 0;
        while (vs_pulses[id] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("vsync_wait", vs_pulses[id], target);
    endtask

    task automatic wait_href_line(input int min_lines, input int budget);
        int n = 0;
        while (!(lines_total[0] >= min_lines && href_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("href_wait", href_a, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_vs;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        run_a = 1'b0; run_b = 1'b0;
        pat_a = 2'd0; pat_b = 2'd0;
        for (int i = 0; i < 2; i++) begin
            mon_reset(i);
            vs_pulses[i] = 0;
            lines_total[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_pclk", pclk_a, 0);
        check_val("rst_vsync", vsync_a, 0);
        check_val("rst_href", href_a, 0);
        check_val("rst_pixel", pixel_a, 0);
        check_val("rst_busy", busy_a, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_busy", busy_a, 0);

        // One white frame, run dropped mid-way through the last line.
        push_frame(0, 0);
        run_a = 1'b1;
        wait_href_line(1, 400);
        run_a = 1'b0;
        wait_busy(0, 1'b0, 400);
        check_val("a1_vsync_pulses", vs_pulses[0], 1);
        check_val("a1_lines", lines_total[0], A_H);
        check_val("a1_sb_left", sb_a.size(), 0);
        repeat (30) @(negedge clk);
        check_val("a1_no_second_vsync", vs_pulses[0], 1);
        check_val("a1_idle_pclk", pclk_a, 0);
`ifdef CAM_SOURCE_FRAME_CNT_EN
        check_val("a1_frame_count", fc_a, exp_fc[0]);
`endif

        // Pattern change mid-frame only applies to the following frame.
        base_vs = vs_pulses[0];
        pat_a = 2'd3;
        push_frame(0, 3);
        run_a = 1'b1;
        wait_vsync(0, base_vs + 1, 100);
        pat_a = 2'd0;
        push_frame(0, 0);
        wait_vsync(0, base_vs + 2, 600);
        run_a = 1'b0;
        wait_busy(0, 1'b0, 600);
        check_val("a2_sb_left", sb_a.size(), 0);
        check_val("a2_vsync_pulses", vs_pulses[0], base_vs + 2);
`ifdef CAM_SOURCE_FRAME_CNT_EN
        check_val("a2_frame_count", fc_a, exp_fc[0]);
`endif

        // Immediate restart out of IDLE.
        push_frame(0, 0);
        run_a = 1'b1;
        wait_busy(0, 1'b1, 2 * A_CD);

        // Asynchronous reset in the middle of a line.
        wait_href_line(lines_total[0], 400);
        #2;
        rst_n_a = 1'b0;
        #1;
        check_val("arst_pclk", pclk_a, 0);
        check_val("arst_vsync", vsync_a, 0);
        check_val("arst_href", href_a, 0);
        check_val("arst_pixel", pixel_a, 0);
        check_val("arst_busy", busy_a, 0);
        mon_reset(0);
`ifdef CAM_SOURCE_FRAME_CNT_EN
        check_val("arst_frame_count", fc_a, 0);
`endif
        repeat (3) @(negedge clk);
        check_val("arst_hold_busy", busy_a, 0);
        base_vs = vs_pulses[0];
        push_frame(0, 0);
        rst_n_a = 1'b1;
        wait_vsync(0, base_vs + 1, 20);
        run_a = 1'b0;
        wait_busy(0, 1'b0, 600);
        check_val("a3_sb_left", sb_a.size(), 0);
`ifdef CAM_SOURCE_FRAME_CNT_EN
        check_val("a3_frame_count", fc_a, exp_fc[0]);
`endif

        // Wide instance: checkerboard, bars, gray ramp on back-to-back frames.
        pat_b = 2'd1;
        push_frame(1, 1);
        run_b = 1'b1;
        wait_vsync(1, 1, 100);
        pat_b = 2'd2;
        push_frame(1, 2);
        wait_vsync(1, 2, 6000);
        pat_b = 2'd3;
        push_frame(1, 3);
        wait_vsync(1, 3, 6000);
        run_b = 1'b0;
        wait_busy(1, 1'b0, 6000);
        check_val("b_sb_left", sb_b.size(), 0);
        check_val("b_lines", lines_total[1], 3 * B_H);
        repeat (20) @(negedge clk);
        check_val("b_vsync_pulses", vs_pulses[1], 3);
`ifdef CAM_SOURCE_FRAME_CNT_EN
        check_val("b_frame_count", fc_b, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_source.md
CAM_SOURCE -- requirements
Module: cam_source

Interface
REQ-001 The parameters SHALL be:
- WIDTH, default 640: active pixels per line.
- HEIGHT, default 480: active lines per frame.
- CLK_DIV, default 4: clk_pixel_in cycles per pclk half-period, legal range 2..255.
- HBLANK, default 16: pclk periods with href low between lines.
- VSYNC_LEN, default 8: pclk periods with vsync high.
- VBACK, default 8: pclk periods between the vsync fall and the first href.
REQ-002 The ports SHALL be, in this order:
- clk_pixel_in  in  1  system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- run_in  in  1  level; high enables frame generation.
- pattern_sel_in  in  2  test pattern select, sampled at each frame start.
- pclk_out  out  1  emulated camera pixel clock.
- vsync_out  out  1  frame sync, active-high.
- href_out  out  1  line valid, active-high.
- pixel_out  out  8  RGB565 byte stream.
- busy_out  out  1  high while a frame is in progress.

Function
REQ-003 The block SHALL act as the transmitting end of the camera byte interface: it drives pclk/vsync/href/pixel for the existing camera/recover capture path.
REQ-004 pclk_out SHALL toggle every CLK_DIV clk_pixel_in cycles whenever the state is not IDLE, and SHALL be held low in IDLE.
REQ-005 All state, counter and output changes SHALL occur only on the clk_pixel_in cycle that drives pclk_out low, so outputs are stable across every pclk_out rising edge.
REQ-006 States and transitions (each count is in pclk periods):
- IDLE -> VSYNC when run_in=1.
- VSYNC (vsync_out=1, VSYNC_LEN periods) -> VBACK.
- VBACK (VBACK periods) -> LINE.
- LINE (href_out=1, 2*WIDTH periods) -> HBLANK.
- HBLANK (HBLANK periods) -> LINE if lines remain, otherwise -> IDLE if run_in=0, otherwise -> VSYNC.
REQ-007 In LINE, each pixel SHALL be sent as two bytes, high byte first: {R[4:0],G[5:3]} then {G[2:0],B[4:0]}.
REQ-008 pixel_out SHALL be 8'h00 whenever href_out=0.
REQ-009 Patterns, with x = pixel column (0..WIDTH-1) and y = line (0..HEIGHT-1):
- 0: solid white, 16'hFFFF.
- 1: checkerboard, white when x[4]^y[4]=0, otherwise black.
- 2: vertical bars, white when x[5]=0, otherwise black.
- 3: gray ramp, R=x[8:4], G={x[8:4],x[8]}, B=x[8:4].
REQ-010 The x, y and byte counters SHALL be sized to clog2 of their maxima. x SHALL wrap to 0 at the end of each LINE; y SHALL wrap to 0 at frame end.
REQ-011 Deasserting run_in mid-frame SHALL NOT truncate the frame: the current frame completes, then the block enters IDLE.
REQ-012 pattern_sel_in changes mid-frame SHALL take effect only at the next VSYNC entry.
REQ-013 busy_out SHALL be 1 in every state except IDLE.
REQ-014 Re-asserting run_in on the same cycle the block enters IDLE SHALL start the next frame within 2*CLK_DIV clk_pixel_in cycles.

Reset
REQ-015 When rst_n_in=0, the block SHALL immediately, asynchronously, enter IDLE with pclk_out=0, vsync_out=0, href_out=0, pixel_out=0, busy_out=0, all counters 0 and the latched pattern 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame with no further bytes emitted. After release, the block SHALL start a fresh frame from VSYNC if run_in=1.

Configuration
REQ-017 With macro CAM_SOURCE_FRAME_CNT_EN defined, the block SHALL add an output port frame_count_out (8 bits). frame_count_out SHALL increment by one, wrapping modulo 256, on each completed frame, and SHALL reset to 0.
REQ-018 Without CAM_SOURCE_FRAME_CNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 Run with WIDTH=4, HEIGHT=2, HBLANK=2, VSYNC_LEN=3, VBACK=2, CLK_DIV=2, pattern 0, for one frame, then run_in=0 -> 3 vsync-high periods, then 2 lines of 8 href-high rising edges each, all bytes 8'hFF, then IDLE with busy_out=0.
REQ-020 Pattern 1, WIDTH=64, at line y=0 -> bytes for x=0..15 are FF,FF; bytes for x=16..31 are 00,00.
REQ-021 Pattern 3, pixel x=256 -> bytes 8'h84,8'h30.
REQ-022 Drop run_in mid-line 1 -> the frame finishes all HEIGHT lines, then IDLE; no second vsync.
REQ-023 Pulse rst_n_in low mid-LINE, asynchronously between clock edges -> all outputs 0 before the next clock edge; with run_in=1 after release, a new vsync pulse follows.
REQ-024 With CAM_SOURCE_FRAME_CNT_EN defined, run 3 frames -> frame_count_out steps 0,1,2,3, and it stays at 3 after run_in drops.
